hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//   Producer of the decoder's block_control stall input, and the pipeline's stall/flush controller.
//   Sits beside ID; watches ID operands, ID/EX load, EX redirects and the MEM data-memory handshake.
//   Drives bubble insertion, PC/IF-ID write enables, flushes and a global freeze.
//   Keeps saturating stall/flush performance counters and a sticky memory-timeout error.
// PARAMETERS
//   CNT_W     32  width of stall_cycles / flush_count performance counters
//   MAX_WAIT  16  max consecutive cycles MEM may wait on mem_ready before timeout (>=1)
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   reset          in   1      synchronous, active-high reset
//   id_rs1         in   5      rs1 field of instruction in ID
//   id_rs2         in   5      rs2 field of instruction in ID
//   id_uses_rs1    in   1      ID instruction reads rs1
//   id_uses_rs2    in   1      ID instruction reads rs2
//   idex_mem_read  in   1      instruction in EX is a load (lw)
//   idex_rd        in   5      destination register of instruction in EX
//   ex_redirect    in   1      EX resolved taken branch / JAL / JALR (PC redirected)
//   mem_req        in   1      MEM stage instruction accesses data memory this cycle
//   mem_ready      in   1      data memory completes access this cycle
//   block_control  out  1      force decoder control outputs to zero (bubble into ID/EX)
//   pc_write       out  1      PC register update enable
//   ifid_write     out  1      IF/ID register update enable
//   ifid_flush     out  1      clear IF/ID to NOP
//   pipe_hold      out  1      freeze ID/EX, EX/MEM, MEM/WB registers
//   mem_timeout    out  1      sticky: memory did not respond within MAX_WAIT cycles
//   stall_cycles   out  CNT_W  count of cycles with pc_write==0 (saturating)
//   flush_count    out  CNT_W  count of applied redirects (saturating)
// BEHAVIOUR
//   States: RUN, MEM_WAIT, ERROR (registered); outputs Mealy on state + inputs.
//   Reset (reset==1 at edge): state=RUN, wait_cnt=0, counters=0, mem_timeout=0.
//     While reset high, outputs forced: block_control=1, ifid_flush=1, pc_write=0,
//     ifid_write=0, pipe_hold=0. Reset mid-wait/mid-error returns cleanly to RUN.
//   load_use = idex_mem_read & idex_rd!=0 &
//              ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)).
//   mem_stall = mem_req & ~mem_ready.
//   RUN, priority high->low:
//     mem_stall: pc_write=0, ifid_write=0, pipe_hold=1, block_control=0; ->MEM_WAIT, wait_cnt=1.
//     ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, block_control=1; flush_count++.
//       (Redirect overrides simultaneous load_use; ID instruction is killed.)
//     load_use: pc_write=0, ifid_write=0, block_control=1 (exactly one bubble; next
//       cycle idex_mem_read is 0 so hazard clears).
//     else: pc_write=1, ifid_write=1, all others 0.
//   MEM_WAIT: outputs as mem_stall freeze.
//     mem_ready: ->RUN; freeze still held this cycle, pipeline advances next cycle.
//     else if wait_cnt==MAX_WAIT: ->ERROR, mem_timeout<=1. else wait_cnt++.
//     ex_redirect/load_use ignored while frozen (EX/ID held; re-evaluated in RUN).
//   ERROR: pc_write=0, ifid_write=0, pipe_hold=1, block_control=1; only reset exits.
//   stall_cycles increments every non-reset cycle with pc_write==0, incl. ERROR.
//   Both counters saturate at all-ones; no wrap.
//   wait_cnt width clog2(MAX_WAIT+1); never exceeds MAX_WAIT.
// TESTING
//   lw x5 in EX, ID add x6,x5,x1 -> one cycle: block_control=1, pc_write=0; next cycle all run.
//   idex_rd=0 with idex_mem_read=1, id_rs1=0 -> no stall (x0 exempt).
//   load_use & ex_redirect same cycle -> ifid_flush=1, pc_write=1, flush_count 0->1.
//   mem_req=1, mem_ready low 3 cycles then high -> pipe_hold=1 for 4 cycles, stall_cycles=4.
//   MAX_WAIT=16, mem_ready never -> mem_timeout=1 after 16 wait cycles; ERROR held.
//   Reset during ERROR -> outputs return to RUN values, counters=0, mem_timeout=0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline stall/flush controller sitting beside ID.
//
// Detects load-use hazards against the load in EX, applies EX redirects as an
// IF/ID flush, and freezes the whole pipeline while the data memory is busy.
// A memory access that waits longer than MAX_WAIT cycles latches a sticky error
// and holds the pipeline until reset.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_rs1, id_rs2                source register fields of the ID instruction
//   id_uses_rs1, id_uses_rs2      ID instruction actually reads rs1 / rs2
//   idex_mem_read, idex_rd        load flag and destination of the EX instruction
//   ex_redirect                   EX redirected the PC (taken branch / jump)
//   mem_req, mem_ready            MEM data-memory request / completion
//   block_control                 zero decoder controls (bubble into ID/EX)
//   pc_write, ifid_write          PC and IF/ID update enables
//   ifid_flush                    clear IF/ID to NOP
//   pipe_hold                     freeze ID/EX, EX/MEM, MEM/WB
//   mem_timeout                   sticky memory-timeout error
//   stall_cycles, flush_count     saturating performance counters
module hazard_stall_unit #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             block_control,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_q, flush_q;
  logic               flush_inc;

  logic load_use;
  logic mem_stall;

  // x0 is never a real dependency, so a load to x0 cannot cause a stall.
  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == idex_rd)));
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    flush_inc     = 1'b0;
    block_control = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    pipe_hold     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end else if (ex_redirect) begin
          // Redirect wins over load-use: the ID instruction is being killed anyway.
          ifid_flush    = 1'b1;
          block_control = 1'b1;
          flush_inc     = 1'b1;
        end else if (load_use) begin
          pc_write      = 1'b0;
          ifid_write    = 1'b0;
          block_control = 1'b1;
        end
      end
      StMemWait: begin
        // Freeze holds through the completing cycle; hazards re-evaluate in StRun.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
        if (mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(MAX_WAIT)) begin
          state_d       = StError;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StError: begin
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        pipe_hold     = 1'b1;
        block_control = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (reset) begin
      block_control = 1'b1;
      ifid_flush    = 1'b1;
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      pipe_hold     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int unsigned CntW    = 4;
  localparam int unsigned MaxWait = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      id_rs1, id_rs2, idex_rd;
  logic            id_uses_rs1, id_uses_rs2, idex_mem_read;
  logic            ex_redirect, mem_req, mem_ready;
  logic            block_control, pc_write, ifid_write, ifid_flush, pipe_hold, mem_timeout;
  logic [CntW-1:0] stall_cycles, flush_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .CNT_W    (CntW),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ex_redirect   (ex_redirect),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .block_control (block_control),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .pipe_hold     (pipe_hold),
    .mem_timeout   (mem_timeout),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    idex_mem_read = 1'b0; idex_rd = 5'd0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    ex_redirect = 1'b1;
    mem_req = 1'b1;
    #1;
    // {block_control, ifid_flush, pc_write, ifid_write, pipe_hold}
    nvec++;
    if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b11000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b expected 11000",
               {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
    end
    step();
    step();
    nvec++;
    if (stall_cycles !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: got stall=%0d flush=%0d to=%b expected 0 0 0",
               stall_cycles, flush_count, mem_timeout);
    end
    clear_inputs();
    reset = 1'b0;
    #1;
    nvec++;
    if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b00110) begin
      nerr++;
      $display("FAIL run_idle: got %b expected 00110",
               {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in EX, add x6,x5,x1 in ID
    idex_mem_read = 1'b1; idex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    #1;
    nvec++;
    if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b10000) begin
      nerr++;
      $display("FAIL load_use_rs1: got %b expected 10000",
               {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
    end
    step();
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    #1;
    nvec++;
    if ({block_control, pc_write, ifid_write} !== 3'b011) begin
      nerr++;
      $display("FAIL load_use_release: got %b expected 011",
               {block_control, pc_write, ifid_write});
    end
    step();
    nvec++;
    if (stall_cycles !== 4'd1) begin
      nerr++;
      $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cycles);
    end
    // rs2 match
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    #1;
    nvec++;
    if ({block_control, pc_write} !== 2'b10) begin
      nerr++;
      $display("FAIL load_use_rs2: got %b expected 10", {block_control, pc_write});
    end
    step();
    // Same registers but rs2 not read: no hazard
    id_uses_rs2 = 1'b0;
    #1;
    nvec++;
    if ({block_control, pc_write} !== 2'b01) begin
      nerr++;
      $display("FAIL load_use_rs2_unused: got %b expected 01", {block_control, pc_write});
    end
    step();
    nvec++;
    if (stall_cycles !== 4'd2) begin
      nerr++;
      $display("FAIL load_use_stall_cnt2: got %0d expected 2", stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_x0_exempt();
    clear_inputs();
    idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    nvec++;
    if ({block_control, pc_write, ifid_write} !== 3'b011) begin
      nerr++;
      $display("FAIL x0_exempt: got %b expected 011", {block_control, pc_write, ifid_write});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_redirect_vs_load_use();
    do_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    ex_redirect = 1'b1;
    #1;
    nvec++;
    if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b11110) begin
      nerr++;
      $display("FAIL redirect_over_load_use: got %b expected 11110",
               {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
    end
    step();
    clear_inputs();
    #1;
    nvec++;
    if (flush_count !== 4'd1 || stall_cycles !== 4'd0) begin
      nerr++;
      $display("FAIL redirect_counters: got flush=%0d stall=%0d expected 1 0",
               flush_count, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // Redirect present from the first cycle: mem_stall outranks it, then it is ignored.
      ex_redirect = 1'b1;
      #1;
      nvec++;
      if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b00001) begin
        nerr++;
        $display("FAIL mem_wait_cycle%0d: got %b expected 00001", i,
                 {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    nvec++;
    if ({pc_write, pipe_hold} !== 2'b01) begin
      nerr++;
      $display("FAIL mem_wait_ready_cycle: got %b expected 01", {pc_write, pipe_hold});
    end
    step();
    clear_inputs();
    #1;
    nvec++;
    if ({pc_write, ifid_write, pipe_hold} !== 3'b110) begin
      nerr++;
      $display("FAIL mem_wait_resume: got %b expected 110", {pc_write, ifid_write, pipe_hold});
    end
    nvec++;
    if (stall_cycles !== 4'd4 || flush_count !== 4'd0) begin
      nerr++;
      $display("FAIL mem_wait_counters: got stall=%0d flush=%0d expected 4 0",
               stall_cycles, flush_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    // One RUN cycle enters the wait with count 1, then counts 1..15 advance to 16.
    for (int i = 0; i < 16; i++) step();
    nvec++;
    if (mem_timeout !== 1'b0 || pipe_hold !== 1'b1 || block_control !== 1'b0) begin
      nerr++;
      $display("FAIL timeout_early: got to=%b hold=%b blk=%b expected 0 1 0",
               mem_timeout, pipe_hold, block_control);
    end
    step();
    nvec++;
    if ({mem_timeout, block_control, pipe_hold, pc_write, ifid_write} !== 5'b11100) begin
      nerr++;
      $display("FAIL timeout_error: got %b expected 11100",
               {mem_timeout, block_control, pipe_hold, pc_write, ifid_write});
    end
    // 17 stall cycles so far, saturated at 15 in a 4-bit counter
    nvec++;
    if (stall_cycles !== 4'd15) begin
      nerr++;
      $display("FAIL stall_saturation: got %0d expected 15", stall_cycles);
    end
    mem_req = 1'b0; mem_ready = 1'b1;
    step();
    nvec++;
    if ({mem_timeout, pc_write, pipe_hold} !== 3'b101) begin
      nerr++;
      $display("FAIL error_held: got %b expected 101", {mem_timeout, pc_write, pipe_hold});
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_error();
    reset = 1'b1;
    #1;
    nvec++;
    if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b11000) begin
      nerr++;
      $display("FAIL error_reset_outputs: got %b expected 11000",
               {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
    end
    step();
    reset = 1'b0;
    #1;
    nvec++;
    if ({block_control, ifid_flush, pc_write, ifid_write, pipe_hold} !== 5'b00110) begin
      nerr++;
      $display("FAIL error_reset_run: got %b expected 00110",
               {block_control, ifid_flush, pc_write, ifid_write, pipe_hold});
    end
    nvec++;
    if (stall_cycles !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
      nerr++;
      $display("FAIL error_reset_state: got stall=%0d flush=%0d to=%b expected 0 0 0",
               stall_cycles, flush_count, mem_timeout);
    end
  endtask

  task automatic test_back_to_back_redirects();
    do_reset();
    ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) step();
    nvec++;
    if (flush_count !== 4'd15 || stall_cycles !== 4'd0 || pc_write !== 1'b1) begin
      nerr++;
      $display("FAIL flush_saturation: got flush=%0d stall=%0d pc=%b expected 15 0 1",
               flush_count, stall_cycles, pc_write);
    end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    test_reset();
    test_load_use();
    test_x0_exempt();
    test_redirect_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_in_error();
    test_back_to_back_redirects();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
